// File: rtl/wb_stage.sv
// Writeback stage: registers MEM->WB fields, selects register-file write data,
// drives the register-file write port and forwarding tap, counts retirements.
module wb_stage #(
   parameter int DATA_W  = 16,
   parameter int IMM_W   = 9,
   parameter int ADDR_W  = 3,
   parameter int CNT_W   = 32,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic [1:0]        in_mem_to_reg,
   input  logic              in_imm_hi,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0] in_alu_out,
   input  logic [DATA_W-1:0] in_dm_data,
   input  logic [DATA_W-1:0] in_pc_plus_2,
   input  logic [IMM_W-1:0]  in_imm,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retired
);

   localparam int PAD_W = DATA_W - IMM_W;

   logic              valid_q;
   logic              reg_write_q;
   logic [1:0]        mem_to_reg_q;
   logic              imm_hi_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] dm_q;
   logic [DATA_W-1:0] pc2_q;
   logic [IMM_W-1:0]  imm_q;
   logic [CNT_W-1:0]  retired_q;

   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] imm_up;
   logic [DATA_W-1:0] wdata;
   logic              wq;

   // Flush only kills valid; the remaining fields are don't-care and simply hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 2'b00;
         imm_hi_q     <= 1'b0;
         rd_q         <= '0;
         alu_q        <= '0;
         dm_q         <= '0;
         pc2_q        <= '0;
         imm_q        <= '0;
      end else if (flush) begin
         valid_q      <= 1'b0;
      end else if (!stall) begin
         valid_q      <= in_valid;
         reg_write_q  <= in_reg_write;
         mem_to_reg_q <= in_mem_to_reg;
         imm_hi_q     <= in_imm_hi;
         rd_q         <= in_rd;
         alu_q        <= in_alu_out;
         dm_q         <= in_dm_data;
         pc2_q        <= in_pc_plus_2;
         imm_q        <= in_imm;
      end
   end

   // Counts every valid instruction that leaves the stage, writing or not.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
      end else if (valid_q && !stall && !flush) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign imm_ext = DATA_W'(imm_q);
   assign imm_up  = imm_ext << PAD_W;

   always_comb begin
      wdata = alu_q;
      case (mem_to_reg_q)
         2'b00:   wdata = alu_q;
         2'b01:   wdata = dm_q;
         2'b10:   wdata = pc2_q;
         default: wdata = imm_hi_q ? imm_up : imm_ext;
      endcase
   end

   assign wq = valid_q & reg_write_q & ~(R0_ZERO & (rd_q == '0));

   // A stalled instruction writes only in the cycle it finally leaves.
   assign rf_we     = wq & ~stall;
   assign rf_addr   = rd_q;
   assign rf_wdata  = wdata;
   assign fwd_valid = wq;
   assign fwd_addr  = rd_q;
   assign fwd_data  = wdata;
   assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: default instance plus a CNT_W=4, R0_ZERO=0 instance
// sharing the same stimulus.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        in_valid, in_reg_write, in_imm_hi;
   logic [1:0]  in_mem_to_reg;
   logic [2:0]  in_rd;
   logic [15:0] in_alu_out, in_dm_data, in_pc_plus_2;
   logic [8:0]  in_imm;

   logic        rf_we, fwd_valid;
   logic [2:0]  rf_addr, fwd_addr;
   logic [15:0] rf_wdata, fwd_data;
   logic [31:0] retired;

   logic        rf_we_b, fwd_valid_b;
   logic [2:0]  rf_addr_b, fwd_addr_b;
   logic [15:0] rf_wdata_b, fwd_data_b;
   logic [3:0]  retired_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_imm_hi(in_imm_hi), .in_rd(in_rd), .in_alu_out(in_alu_out),
      .in_dm_data(in_dm_data), .in_pc_plus_2(in_pc_plus_2), .in_imm(in_imm),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .retired(retired)
   );

   wb_stage #(.CNT_W(4), .R0_ZERO(1'b0)) dut_b (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_imm_hi(in_imm_hi), .in_rd(in_rd), .in_alu_out(in_alu_out),
      .in_dm_data(in_dm_data), .in_pc_plus_2(in_pc_plus_2), .in_imm(in_imm),
      .rf_we(rf_we_b), .rf_addr(rf_addr_b), .rf_wdata(rf_wdata_b),
      .fwd_valid(fwd_valid_b), .fwd_addr(fwd_addr_b), .fwd_data(fwd_data_b),
      .retired(retired_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 2'b00; in_imm_hi = 1'b0;
      in_rd = 3'd5; in_alu_out = 16'hFFFF; in_dm_data = 16'h0; in_pc_plus_2 = 16'h0;
      in_imm = 9'h0;

      // reset held two cycles with valid input
      tick(); tick();
      chk("rst_rf_we",     32'(rf_we),     32'h0);
      chk("rst_fwd_valid", 32'(fwd_valid), 32'h0);
      chk("rst_retired",   retired,        32'h0);
      chk("rst_rf_addr",   32'(rf_addr),   32'h0);
      chk("rst_rf_wdata",  32'(rf_wdata),  32'h0);
      chk("rst_retired_b", 32'(retired_b), 32'h0);

      // first instruction, one cycle latency
      rst = 1'b0; in_rd = 3'd3; in_alu_out = 16'h1234;
      #1;
      chk("first_pre_we", 32'(rf_we), 32'h0);
      tick();
      chk("first_we",     32'(rf_we),    32'h1);
      chk("first_addr",   32'(rf_addr),  32'h3);
      chk("first_wdata",  32'(rf_wdata), 32'h1234);
      chk("first_fwd_a",  32'(fwd_addr), 32'h3);
      chk("first_fwd_d",  32'(fwd_data), 32'h1234);
      chk("first_ret",    retired,       32'h0);

      // select sweep
      in_mem_to_reg = 2'b01; in_dm_data = 16'hBEEF; tick();
      chk("sel01_wdata", 32'(rf_wdata), 32'hBEEF);
      chk("sel01_ret",   retired,       32'h1);
      in_mem_to_reg = 2'b10; in_pc_plus_2 = 16'h0042; tick();
      chk("sel10_wdata", 32'(rf_wdata), 32'h0042);
      chk("sel10_ret",   retired,       32'h2);
      in_mem_to_reg = 2'b11; in_imm = 9'h1AB; in_imm_hi = 1'b0; tick();
      chk("lli_wdata",   32'(rf_wdata), 32'h01AB);
      chk("lli_ret",     retired,       32'h3);
      in_imm_hi = 1'b1; tick();
      chk("lhi_wdata",   32'(rf_wdata), 32'hD580);
      chk("lhi_fwd_d",   32'(fwd_data), 32'hD580);
      chk("lhi_ret",     retired,       32'h4);

      // stall three cycles on a writing instruction
      in_mem_to_reg = 2'b00; in_imm_hi = 1'b0; in_alu_out = 16'h5555; in_rd = 3'd2; tick();
      chk("pre_stall_we", 32'(rf_we), 32'h1);
      chk("pre_stall_ret", retired,   32'h5);
      stall = 1'b1; in_reg_write = 1'b0; in_alu_out = 16'h7777; in_rd = 3'd6;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_we",    32'(rf_we),     32'h0);
         chk("stall_fwd_v", 32'(fwd_valid), 32'h1);
         chk("stall_wdata", 32'(rf_wdata),  32'h5555);
         chk("stall_addr",  32'(rf_addr),   32'h2);
         chk("stall_ret",   retired,        32'h5);
         if (i < 2) tick();
      end
      stall = 1'b0;
      #1;
      chk("release_we",  32'(rf_we), 32'h1);
      chk("release_ret", retired,    32'h5);

      // non-writing instruction enters after release
      tick();
      chk("nowrite_we",    32'(rf_we),     32'h0);
      chk("nowrite_fwd_v", 32'(fwd_valid), 32'h0);
      chk("nowrite_wdata", 32'(rf_wdata),  32'h7777);
      chk("nowrite_ret",   retired,        32'h6);

      // stall and flush together discard the held instruction
      in_reg_write = 1'b1; in_alu_out = 16'h0A0A; in_rd = 3'd1; tick();
      chk("sf_pre_we",  32'(rf_we), 32'h1);
      chk("sf_pre_ret", retired,    32'h7);
      stall = 1'b1; flush = 1'b1; in_alu_out = 16'h0B0B;
      #1;
      chk("sf_stall_we", 32'(rf_we), 32'h0);
      tick();
      chk("sf_fwd_v", 32'(fwd_valid), 32'h0);
      chk("sf_we",    32'(rf_we),     32'h0);
      chk("sf_ret",   retired,        32'h7);
      stall = 1'b0; flush = 1'b0;

      // R0 write: suppressed on default instance, allowed with R0_ZERO=0
      in_rd = 3'd0; in_alu_out = 16'h0C0C; tick();
      chk("r0_we",      32'(rf_we),      32'h0);
      chk("r0_fwd_v",   32'(fwd_valid),  32'h0);
      chk("r0_we_b",    32'(rf_we_b),    32'h1);
      chk("r0_addr_b",  32'(rf_addr_b),  32'h0);
      chk("r0_wdata_b", 32'(rf_wdata_b), 32'h0C0C);
      chk("r0_ret",     retired,         32'h7);
      flush = 1'b1; in_rd = 3'd4; tick();
      chk("flush_fwd_v_b", 32'(fwd_valid_b), 32'h0);
      chk("flush_we_b",    32'(rf_we_b),     32'h0);
      chk("flush_ret",     retired,          32'h7);
      chk("flush_ret_b",   32'(retired_b),   32'h7);
      flush = 1'b0;

      // reset while stalled
      in_rd = 3'd5; in_alu_out = 16'h0D0D; tick();
      chk("rs_pre_fwd_v", 32'(fwd_valid), 32'h1);
      stall = 1'b1; rst = 1'b1; tick();
      chk("rs_fwd_v",  32'(fwd_valid), 32'h0);
      chk("rs_we",     32'(rf_we),     32'h0);
      chk("rs_wdata",  32'(rf_wdata),  32'h0);
      chk("rs_ret",    retired,        32'h0);
      chk("rs_ret_b",  32'(retired_b), 32'h0);
      stall = 1'b0; rst = 1'b0;

      // 17 retirements: 4-bit counter wraps to 1
      for (int i = 0; i < 18; i++) begin
         in_alu_out = 16'(i);
         tick();
         if (i == 16) chk("wrap0_ret_b", 32'(retired_b), 32'h0);
      end
      chk("wrap_ret",   retired,        32'd17);
      chk("wrap_ret_b", 32'(retired_b), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised writeback stage that succeeds the purely combinational writeback select. It registers the MEM→WB pipeline fields and selects the register-file write data from ALU result, data-memory load, return address, or a zero-extended (LLI) or upper-placed (LHI) immediate. It then drives the register-file write port and a forwarding tap. It sits between the memory stage and the register file, supports stall and flush, and keeps a retired-instruction counter.

## Interface
- DATA_W, 16, datapath width.
- IMM_W, 9, immediate width; must satisfy IMM_W ≤ DATA_W.
- ADDR_W, 3, register-address width.
- CNT_W, 32, retired-instruction counter width.
- R0_ZERO, 1, when 1, writes to register 0 are suppressed.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the stage register.
- flush  in  1  invalidate the stage register.
- in_valid  in  1  memory-stage instruction valid.
- in_reg_write  in  1  instruction writes the register file.
- in_mem_to_reg  in  2  source select: 00 ALU, 01 memory, 10 PC+2, 11 immediate.
- in_imm_hi  in  1  for select 11 only: 0 = LLI zero-extend, 1 = LHI upper placement.
- in_rd  in  ADDR_W  destination register.
- in_alu_out, in_dm_data, in_pc_plus_2  in  DATA_W  candidate sources.
- in_imm  in  IMM_W  immediate.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- fwd_valid  out  1  stage holds a valid register-writing instruction.
- fwd_addr  out  ADDR_W  forwarding address, equal to rf_addr.
- fwd_data  out  DATA_W  forwarding data, equal to rf_wdata.
- retired  out  CNT_W  count of instructions leaving the stage.

## Operation
- **Stage register fields:**
  - valid
  - reg_write
  - mem_to_reg
  - imm_hi
  - rd
  - alu, dm, pc2
  - imm
- **Update priority at each rising edge**, highest first:
  - rst: all fields and retired cleared to 0.
  - flush: valid cleared to 0; other fields don't-care. Flush wins over stall.
  - stall: all fields hold.
  - Otherwise: all fields load from the in_* inputs.
- **Write-data select** (combinational from the registered fields):
  - 00 → alu
  - 01 → dm
  - 10 → pc2
  - 11, imm_hi=0 → {(DATA_W-IMM_W) zeros, imm}
  - 11, imm_hi=1 → {imm, (DATA_W-IMM_W) zeros}
  - When IMM_W = DATA_W, both immediate forms equal imm.
- **Write qualification:**
  - Define wq = valid & reg_write & ~(R0_ZERO & (rd == 0)).
  - fwd_valid = wq.
  - rf_we = wq & ~stall. A stalled instruction writes exactly once, in the cycle it leaves.
- **Retired counter:** increments by 1 on each edge where valid=1, stall=0, flush=0 and rst=0. This counts all valid instructions, not only those that write. It wraps modulo 2^CNT_W.

## Timing
- **Latency:** inputs sampled at edge N appear on rf_*/fwd_* after edge N, one cycle later. The register file writes at edge N+1.
- **Reset values:** rf_we=0, fwd_valid=0, rf_addr=0, rf_wdata=0 (select 00, alu=0), retired=0.
- **Output paths:** rf_wdata, fwd_data, rf_addr and fwd_addr are pure functions of registered state. rf_we is the only output with a combinational input path, through stall.
- **Stall:** outputs remain constant for the whole stall duration. fwd_valid stays asserted so that younger instructions can forward.
- **Simultaneous stall and flush:** flush applies; the held instruction is discarded without a write and without being counted.
- **Reset mid-stall:** next cycle is empty, retired=0, and no write of the held instruction occurs.
- **Counter wrap:** when retired is all ones, the next qualifying edge yields 0.

## Test plan
- **Reset:** hold rst 2 cycles with in_valid=1 → rf_we=0, fwd_valid=0, retired=0. First instruction after release (alu=0x1234, sel 00, rd=3, reg_write=1) → rf_we=1, rf_addr=3, rf_wdata=0x1234 exactly one cycle later.
- **Select sweep:** defaults, back-to-back: sel 01 dm=0xBEEF; sel 10 pc2=0x0042; sel 11 imm=0x1AB imm_hi=0; sel 11 imm=0x1AB imm_hi=1 → rf_wdata 0xBEEF, 0x0042, 0x01AB, 0xD580 on consecutive cycles; retired advances 1 per cycle.
- **Stall then release:** stall 3 cycles on a writing instruction → rf_we=0, fwd_valid=1 and data stable for 3 cycles. On release, rf_we=1 for exactly 1 cycle and retired increments once.
- **Flush:**
  - stall=1 and flush=1 on the same edge → next cycle fwd_valid=0, no write, retired unchanged.
  - Flush with an R0 write (rd=0) under R0_ZERO=1 → rf_we=0.
  - R0_ZERO=0, rd=0 → rf_we=1.
- **Non-writing instruction:** reg_write=0, valid=1 → rf_we=0, fwd_valid=0, retired still increments.
- **Wrap:** CNT_W=4, retire 17 instructions → retired=1.
